// File: rtl/record_play_ctrl_if.sv
// Sample BRAM port bundle: the controller drives address/write side, the BRAM returns read data.
interface record_play_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] mem_addr_out;
  logic              mem_we_out;
  logic [DATA_W-1:0] mem_din_out;
  logic [DATA_W-1:0] mem_dout_in;

  modport master (
    output mem_addr_out,
    output mem_we_out,
    output mem_din_out,
    input  mem_dout_in
  );

  modport slave (
    input  mem_addr_out,
    input  mem_we_out,
    input  mem_din_out,
    output mem_dout_in
  );
endinterface

// File: rtl/record_play_ctrl.sv
// Record/playback sequencer for the single-port audio sample BRAM.
//
// state  | meaning
// IDLE   | waiting for record level or play rising edge
// RECORD | writing one sample per audio strobe from address 0 upward
// PLAY   | reading the take back, one sample per audio strobe
module record_play_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 record_in,
  input  logic                 play_in,
  input  logic                 loop_in,
  input  logic                 audio_valid_in,
  input  logic [DATA_W-1:0]    audio_in,
  record_play_ctrl_if.master   mem,
  output logic [DATA_W-1:0]    single_out,
  output logic                 single_valid_out,
  output logic [31:0]          recording_length,
  output logic [1:0]           state_out,
  output logic                 finish
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   len_q;
  logic              play_q;
  logic              stopped;
  logic              val1, last1, val2, last2;

  logic              rec_wr, rec_full, play_iss, play_last, keep_play, play_rise;

  assign play_rise        = play_in && !play_q;
  assign recording_length = 32'(len_q);
  assign state_out        = state_q;

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and the per-cycle write/read issue strobes.
  always_comb begin
    state_d   = state_q;
    rec_wr    = 1'b0;
    rec_full  = 1'b0;
    play_iss  = 1'b0;
    play_last = 1'b0;
    keep_play = 1'b0;
    case (state_q)
      IDLE: begin
        if (record_in)                        state_d = RECORD;
        else if (play_rise && len_q != '0)    state_d = PLAY;
      end
      RECORD: begin
        rec_wr   = record_in && audio_valid_in;
        rec_full = rec_wr && (wr_ptr == '1);
        if (!record_in || rec_full) state_d = IDLE;
      end
      PLAY: begin
        // A record request discards everything still in the read pipeline.
        keep_play = !record_in;
        play_iss  = keep_play && audio_valid_in && !stopped;
        play_last = play_iss && ({1'b0, rd_ptr} == len_q - (ADDR_W+1)'(1));
        if (record_in)   state_d = RECORD;
        else if (finish) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pointers, take length, BRAM port registers and the 3-stage playback pipeline.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      len_q            <= '0;
      play_q           <= 1'b0;
      stopped          <= 1'b0;
      val1             <= 1'b0;
      last1            <= 1'b0;
      val2             <= 1'b0;
      last2            <= 1'b0;
      mem.mem_addr_out <= '0;
      mem.mem_we_out   <= 1'b0;
      mem.mem_din_out  <= '0;
      single_out       <= '0;
      single_valid_out <= 1'b0;
      finish           <= 1'b0;
    end else begin
      play_q           <= play_in;
      mem.mem_we_out   <= rec_wr;
      val1             <= play_iss;
      last1            <= play_last && !loop_in;
      val2             <= val1 && keep_play;
      last2            <= last1 && keep_play;
      single_valid_out <= val2 && keep_play;
      finish           <= rec_full || (last2 && keep_play);
      if (val2 && keep_play) single_out <= mem.mem_dout_in;

      if (rec_wr) begin
        mem.mem_addr_out <= wr_ptr;
        mem.mem_din_out  <= audio_in;
        wr_ptr           <= wr_ptr + ADDR_W'(1);
        len_q            <= len_q + (ADDR_W+1)'(1);
      end

      if (play_iss) begin
        mem.mem_addr_out <= rd_ptr;
        if (play_last) begin
          if (loop_in) rd_ptr  <= '0;
          else         stopped <= 1'b1;
        end else begin
          rd_ptr <= rd_ptr + ADDR_W'(1);
        end
      end

      // A new take always starts from address 0 with an empty length.
      if (state_d == RECORD && state_q != RECORD) begin
        wr_ptr <= '0;
        len_q  <= '0;
      end
      if (state_d == PLAY && state_q == IDLE) begin
        rd_ptr  <= '0;
        stopped <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_record_play_ctrl.sv
// Scoreboard bench for record_play_ctrl with a small BRAM (ADDR_W=4) so the full-buffer case is reachable.
module tb_record_play_ctrl;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              record_in = 1'b0;
  logic              play_in = 1'b0;
  logic              loop_in = 1'b0;
  logic              audio_valid = 1'b0;
  logic [DATA_W-1:0] audio_in = '0;
  logic [DATA_W-1:0] single_out;
  logic              single_valid;
  logic [31:0]       recording_length;
  logic [1:0]        state_out;
  logic              finish;

  logic [31:0]       cyc = '0;
  int                n_vec = 0;
  int                n_err = 0;
  int                fin_cnt = 0;
  logic [31:0]       fin_cyc = '0;

  exp_t              wr_q[$];
  exp_t              rd_q[$];
  logic [DATA_W-1:0] exp_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] ram     [0:(1<<ADDR_W)-1];
  int                model_wp = 0;
  logic [31:0]       last_strobe_cyc = '0;

  record_play_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

  record_play_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_in           (clk),
    .rst_in           (rst),
    .record_in        (record_in),
    .play_in          (play_in),
    .loop_in          (loop_in),
    .audio_valid_in   (audio_valid),
    .audio_in         (audio_in),
    .mem              (mem_bus),
    .single_out       (single_out),
    .single_valid_out (single_valid),
    .recording_length (recording_length),
    .state_out        (state_out),
    .finish           (finish)
  );

  always #5 clk = ~clk;

  // Cycle counter used to time-stamp strobes and outputs.
  always @(posedge clk) cyc <= cyc + 32'd1;

  // BRAM model with one cycle of read latency.
  always @(posedge clk) begin
    if (mem_bus.mem_we_out) ram[mem_bus.mem_addr_out] <= mem_bus.mem_din_out;
    mem_bus.mem_dout_in <= ram[mem_bus.mem_addr_out];
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Output monitor: pops scoreboard entries whenever the DUT writes or emits a sample.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (!rst) begin
      if (mem_bus.mem_we_out) begin
        if (wr_q.size() == 0) check_val("wr_unexpected", 32'd1, 32'd0);
        else begin
          e = wr_q.pop_front();
          check_val("wr_addr", 32'(mem_bus.mem_addr_out), e.addr);
          check_val("wr_data", 32'(mem_bus.mem_din_out), e.data);
          check_val("wr_latency", cyc, e.cyc + 32'd1);
        end
      end
      if (single_valid) begin
        if (rd_q.size() == 0) check_val("rd_unexpected", 32'd1, 32'd0);
        else begin
          e = rd_q.pop_front();
          check_val("rd_data", 32'(single_out), e.data);
          check_val("rd_latency", cyc, e.cyc + 32'd3);
        end
      end
      if (finish) begin
        fin_cnt++;
        fin_cyc = cyc;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic push_wr(input logic [DATA_W-1:0] d);
    exp_t e;
    e.cyc  = cyc;
    e.addr = 32'(model_wp);
    e.data = 32'(d);
    wr_q.push_back(e);
    exp_mem[model_wp] = d;
    model_wp++;
  endtask

  task automatic strobe_rec(input logic [DATA_W-1:0] d);
    audio_valid = 1'b1;
    audio_in    = d;
    push_wr(d);
    tick();
    audio_valid = 1'b0;
  endtask

  task automatic strobe_play(input bit push, input int idx);
    exp_t e;
    audio_valid = 1'b1;
    last_strobe_cyc = cyc;
    if (push) begin
      e.cyc  = cyc;
      e.addr = 32'(idx);
      e.data = 32'(exp_mem[idx]);
      rd_q.push_back(e);
    end
    tick();
    audio_valid = 1'b0;
  endtask

  task automatic pulse_play;
    play_in = 1'b1;
    tick();
    play_in = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    bit seen;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset in the middle of a recording.
    record_in = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) strobe_rec(DATA_W'(50 + i));
    rst = 1'b1;
    tick();
    check_val("rst_state", 32'(state_out), 32'd0);
    check_val("rst_length", recording_length, 32'd0);
    check_val("rst_we", 32'(mem_bus.mem_we_out), 32'd0);
    check_val("rst_addr", 32'(mem_bus.mem_addr_out), 32'd0);
    check_val("rst_din", 32'(mem_bus.mem_din_out), 32'd0);
    check_val("rst_single", 32'(single_out), 32'd0);
    check_val("rst_valid", 32'(single_valid), 32'd0);
    check_val("rst_finish", 32'(finish), 32'd0);
    record_in = 1'b0;
    rst = 1'b0;
    tick();

    // Play request with an empty take is ignored.
    pulse_play();
    check_val("play_empty_state", 32'(state_out), 32'd0);
    tick();
    check_val("play_empty_state2", 32'(state_out), 32'd0);

    // Record 10 back-to-back samples.
    f0 = fin_cnt;
    record_in = 1'b1;
    tick();
    check_val("rec_state", 32'(state_out), 32'd1);
    model_wp = 0;
    for (int i = 0; i < 10; i++) strobe_rec(DATA_W'(i));
    check_val("rec_length", recording_length, 32'd10);
    record_in = 1'b0;
    repeat (2) tick();
    check_val("rec_idle", 32'(state_out), 32'd0);
    check_val("rec_no_finish", 32'(fin_cnt), 32'(f0));
    check_val("rec_wr_drained", 32'(wr_q.size()), 32'd0);

    // One-shot playback, one strobe every 7 cycles.
    loop_in = 1'b0;
    f0 = fin_cnt;
    pulse_play();
    check_val("play_state", 32'(state_out), 32'd2);
    for (int i = 0; i < 10; i++) begin
      strobe_play(1'b1, i);
      if (i < 9) repeat (6) tick();
    end
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      if (finish) seen = 1'b1;
      else tick();
    end
    check_val("play_finish_seen", 32'(seen), 32'd1);
    check_val("play_finish_with_valid", 32'(single_valid), 32'd1);
    check_val("play_finish_cycle", cyc, last_strobe_cyc + 32'd3);
    tick();
    check_val("play_idle_after", 32'(state_out), 32'd0);
    check_val("play_finish_count", 32'(fin_cnt), 32'(f0 + 1));
    check_val("play_rd_drained", 32'(rd_q.size()), 32'd0);

    // Looped playback: 25 strobes wrap through the 10-sample take.
    loop_in = 1'b1;
    f0 = fin_cnt;
    pulse_play();
    for (int i = 0; i < 25; i++) begin
      strobe_play(1'b1, i % 10);
      repeat (6) tick();
    end
    check_val("loop_no_finish", 32'(fin_cnt), 32'(f0));
    check_val("loop_rd_drained", 32'(rd_q.size()), 32'd0);
    check_val("loop_still_play", 32'(state_out), 32'd2);

    // Record request pre-empts playback; the in-flight read must not surface.
    strobe_play(1'b0, 0);
    record_in = 1'b1;
    tick();
    check_val("preempt_state", 32'(state_out), 32'd1);
    check_val("preempt_length", recording_length, 32'd0);
    repeat (4) tick();
    loop_in = 1'b0;
    model_wp = 0;
    for (int i = 0; i < 3; i++) strobe_rec(DATA_W'(200 + i));
    check_val("preempt_length_restart", recording_length, 32'd3);
    record_in = 1'b0;
    repeat (2) tick();

    // Fill the whole 16-entry buffer; extra strobes are dropped.
    f0 = fin_cnt;
    record_in = 1'b1;
    tick();
    model_wp = 0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (finish && !seen) begin
        seen = 1'b1;
        record_in = 1'b0;
        check_val("full_fin_we", 32'(mem_bus.mem_we_out), 32'd1);
        check_val("full_fin_addr", 32'(mem_bus.mem_addr_out), 32'd15);
        check_val("full_fin_state", 32'(state_out), 32'd0);
      end
      audio_valid = 1'b1;
      audio_in    = DATA_W'(100 + i);
      if (i < 16) push_wr(DATA_W'(100 + i));
      tick();
    end
    audio_valid = 1'b0;
    repeat (3) tick();
    check_val("full_finish_seen", 32'(seen), 32'd1);
    check_val("full_finish_count", 32'(fin_cnt), 32'(f0 + 1));
    check_val("full_length", recording_length, 32'd16);
    check_val("full_state", 32'(state_out), 32'd0);
    check_val("full_wr_drained", 32'(wr_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
